rl_step_sequencer: RTL and testbench
====================================

RL_STEP_SEQUENCER -- requirements
Module: rl_step_sequencer

Interface
REQ-001 Parameter W, default 32, SHALL set the datapath, accumulator and i_out width in bits.
REQ-002 Parameter STEP_W, default 16, SHALL set the n_steps and step_cnt width in bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be an asynchronous active-high reset.
REQ-005 Port start, input, 1, SHALL request a run of n_steps integration steps.
REQ-006 Port abort, input, 1, SHALL terminate a run in progress.
REQ-007 Port n_steps, input, STEP_W, SHALL give the number of steps per run (unsigned).
REQ-008 Ports r_coef, l_div, u0, dt, input, 16 each, SHALL give the signed Q.0 model coefficients R, 1/L, U0, dt.
REQ-009 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.
REQ-010 Port done, output, 1, SHALL pulse high for one cycle at normal run completion.
REQ-011 Port i_out, output, W, SHALL carry the signed current estimate I.
REQ-012 Port i_valid, output, 1, SHALL pulse high for one cycle each time i_out updates.
REQ-013 Port step_cnt, output, STEP_W, SHALL carry the number of steps completed in the current run.

Function
REQ-014 FSM states SHALL be IDLE, MUL_R, SUB, MUL_L, MUL_DT, ACC, UPD, DONE; every state except IDLE lasts exactly one cycle.
REQ-015 The block SHALL use one shared signed multiplier, with operands muxed by state: MUL_R x0=r_coef*I; MUL_L x2=x1*l_div; MUL_DT di=x2*dt.
REQ-016 SUB SHALL compute x1=u0-x0; ACC SHALL compute acc=acc+(di>>>10); UPD SHALL compute I=acc>>>8, increment step_cnt and pulse i_valid.
REQ-017 All products and sums SHALL be W-bit two's complement truncated (wrap), except as given by REQ-026; all shifts SHALL be arithmetic.
REQ-018 start sampled high in IDLE SHALL latch n_steps and all coefficients, clear acc, I and step_cnt, and enter MUL_R, or enter DONE if n_steps==0.
REQ-019 After UPD, the FSM SHALL enter DONE if step_cnt (post-increment) equals the latched n_steps, else return to MUL_R; one step SHALL take 6 cycles.
REQ-020 DONE SHALL assert done for its single cycle and then return to IDLE; busy SHALL be low in that cycle.
REQ-021 With start sampled at edge E0, the first i_valid SHALL appear after edge E6, step k after edge E(6k), and done after edge E(6N+1).
REQ-022 start while not in IDLE SHALL be ignored; input coefficient changes during a run SHALL have no effect.
REQ-023 abort high in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; I, acc and step_cnt SHALL be retained; abort SHALL take priority over start and over the UPD-to-DONE transition.
REQ-024 i_out SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-025 rst high SHALL immediately force IDLE and set busy=0, done=0, i_valid=0, i_out=0, step_cnt=0, acc=0, and all intermediates and latched coefficients to 0, regardless of clock, including mid-run.

Configuration
REQ-026 With macro RL_SEQ_SAT_EN defined, the ACC addition SHALL saturate to +(2^(W-1)-1) or -2^(W-1); without it, the addition SHALL wrap modulo 2^W.

Verification
REQ-027 r=10, l_div=100, u0=200, dt=26, n_steps=2, start -> i_valid after E6 with i_out=1 (acc=507); after E12 i_out=3 (acc=989); done after E13; step_cnt=2.
REQ-028 n_steps=0, start -> done after E1, no i_valid, i_out=0, busy high for exactly one cycle.
REQ-029 Run n_steps=5, abort asserted in the cycle after the 2nd i_valid -> IDLE next edge, no done, step_cnt=2, i_out retained; a subsequent start restarts from I=0.
REQ-030 r=0, l_div=1000, u0=1000, dt=2000, n_steps=1100 -> with RL_SEQ_SAT_EN the final i_out=8388607; without it, final i_out=-8384883.
REQ-031 rst pulsed mid-step (state MUL_L) -> all outputs 0 asynchronously; start asserted during busy -> ignored, and the run length is unchanged.

Source files
------------

// File: rtl/rl_step_sequencer.sv
// RL circuit Euler integrator: one shared multiplier, six cycles per step.
// Define RL_SEQ_SAT_EN to make the accumulator add saturate instead of wrap.
module rl_step_sequencer #(
   parameter int W      = 32,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [STEP_W-1:0] n_steps,
   input  logic [15:0]       r_coef,
   input  logic [15:0]       l_div,
   input  logic [15:0]       u0,
   input  logic [15:0]       dt,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      i_out,
   output logic              i_valid,
   output logic [STEP_W-1:0] step_cnt
);

   typedef enum logic [2:0] {
      IDLE, MUL_R, SUB, MUL_L, MUL_DT, ACC, UPD, DONE
   } state_t;

   state_t state;

   logic signed [15:0]   r_q;
   logic signed [15:0]   l_q;
   logic signed [15:0]   u_q;
   logic signed [15:0]   dt_q;
   logic [STEP_W-1:0]    n_q;

   logic signed [W-1:0]  cur;
   logic signed [W-1:0]  acc;
   logic signed [W-1:0]  x0;
   logic signed [W-1:0]  x1;
   logic signed [W-1:0]  x2;
   logic signed [W-1:0]  di;

   logic signed [W-1:0]  mul_a;
   logic signed [W-1:0]  mul_b;
   logic signed [W-1:0]  prod;
   logic signed [W-1:0]  di_sh;
   logic signed [W-1:0]  acc_nxt;
   logic [STEP_W-1:0]    cnt_nxt;

   assign busy    = (state != IDLE);
   assign i_out   = cur;
   assign cnt_nxt = step_cnt + STEP_W'(1);
   assign di_sh   = di >>> 10;

   // Single multiplier; operands chosen by the current phase of the step.
   always_comb begin
      mul_a = cur;
      mul_b = W'(r_q);
      case (state)
         MUL_L: begin
            mul_a = x1;
            mul_b = W'(l_q);
         end
         MUL_DT: begin
            mul_a = x2;
            mul_b = W'(dt_q);
         end
         default: begin
            mul_a = cur;
            mul_b = W'(r_q);
         end
      endcase
   end

   assign prod = mul_a * mul_b;

`ifdef RL_SEQ_SAT_EN
   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic signed [W:0] sum_x;

   always_comb begin
      sum_x = {acc[W-1], acc} + {di_sh[W-1], di_sh};
      if (sum_x[W] != sum_x[W-1])
         acc_nxt = sum_x[W] ? SAT_MIN : SAT_MAX;
      else
         acc_nxt = sum_x[W-1:0];
   end
`else
   assign acc_nxt = acc + di_sh;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         done     <= 1'b0;
         i_valid  <= 1'b0;
         step_cnt <= '0;
         cur      <= '0;
         acc      <= '0;
         x0       <= '0;
         x1       <= '0;
         x2       <= '0;
         di       <= '0;
         r_q      <= '0;
         l_q      <= '0;
         u_q      <= '0;
         dt_q     <= '0;
         n_q      <= '0;
      end else begin
         done    <= 1'b0;
         i_valid <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     r_q      <= r_coef;
                     l_q      <= l_div;
                     u_q      <= u0;
                     dt_q     <= dt;
                     n_q      <= n_steps;
                     acc      <= '0;
                     cur      <= '0;
                     step_cnt <= '0;
                     state    <= (n_steps == '0) ? DONE : MUL_R;
                  end
               end
               MUL_R: begin
                  x0    <= prod;
                  state <= SUB;
               end
               SUB: begin
                  x1    <= W'(u_q) - x0;
                  state <= MUL_L;
               end
               MUL_L: begin
                  x2    <= prod;
                  state <= MUL_DT;
               end
               MUL_DT: begin
                  di    <= prod;
                  state <= ACC;
               end
               ACC: begin
                  acc   <= acc_nxt;
                  state <= UPD;
               end
               UPD: begin
                  cur      <= acc >>> 8;
                  step_cnt <= cnt_nxt;
                  i_valid  <= 1'b1;
                  state    <= (cnt_nxt == n_q) ? DONE : MUL_R;
               end
               DONE: begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rl_step_sequencer.sv
// Bench for rl_step_sequencer: directed and random runs against a step model.
module tb_rl_step_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] n_steps;
   logic [15:0] r_coef;
   logic [15:0] l_div;
   logic [15:0] u0;
   logic [15:0] dt;
   logic        busy;
   logic        done;
   logic [31:0] i_out;
   logic        i_valid;
   logic [15:0] step_cnt;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   rl_step_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .n_steps  (n_steps),
      .r_coef   (r_coef),
      .l_div    (l_div),
      .u0       (u0),
      .dt       (dt),
      .busy     (busy),
      .done     (done),
      .i_out    (i_out),
      .i_valid  (i_valid),
      .step_cnt (step_cnt)
   );

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One Euler step of dI/dt = (U0 - R*I)/L, in 32-bit wrapping arithmetic.
   function automatic int model_acc(int a, int ii, int r, int l, int u, int d);
      int     x0;
      int     x1;
      int     x2;
      int     dv;
      longint s;
      x0 = r * ii;
      x1 = u - x0;
      x2 = x1 * l;
      dv = x2 * d;
      s  = longint'(a) + longint'(dv >>> 10);
`ifdef RL_SEQ_SAT_EN
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      return int'(s);
   endfunction

   task automatic run(input shortint r, input shortint l,
                      input shortint u, input shortint d,
                      input int n, input bit noise, input string tag);
      int  a  = 0;
      int  ii = 0;
      int  k  = 0;
      bit  ev;
      @(negedge clk);
      r_coef  = r;
      l_div   = l;
      u0      = u;
      dt      = d;
      n_steps = 16'(n);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ":busy_e0"}, busy, 1);
      for (int c = 1; c <= 6 * n + 1; c++) begin
         if (noise) begin
            start   = 1'($urandom);
            n_steps = 16'($urandom);
            r_coef  = 16'($urandom);
            l_div   = 16'($urandom);
            u0      = 16'($urandom);
            dt      = 16'($urandom);
         end
         @(negedge clk);
         ev = (c % 6 == 0);
         if (ev) begin
            a  = model_acc(a, ii, r, l, u, d);
            ii = a >>> 8;
            k++;
         end
         chk({tag, ":i_valid"}, i_valid, ev);
         chk({tag, ":done"}, done, (c == 6 * n + 1));
         chk({tag, ":busy"}, busy, (c <= 6 * n));
         if (ev) begin
            chk({tag, ":i_out"}, $signed(i_out), ii);
            chk({tag, ":step_cnt"}, step_cnt, k);
         end
      end
      start = 1'b0;
      chk({tag, ":final_i"}, $signed(i_out), ii);
      chk({tag, ":final_cnt"}, step_cnt, n);
      repeat (3) begin
         @(negedge clk);
         chk({tag, ":hold_i"}, $signed(i_out), ii);
         chk({tag, ":idle_done"}, done, 0);
         chk({tag, ":idle_busy"}, busy, 0);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      n_steps = '0;
      r_coef  = '0;
      l_div   = '0;
      u0      = '0;
      dt      = '0;
      #12;
      chk("rst:busy", busy, 0);
      chk("rst:done", done, 0);
      chk("rst:i_valid", i_valid, 0);
      chk("rst:i_out", $signed(i_out), 0);
      chk("rst:step_cnt", step_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reference two-step example
      run(10, 100, 200, 26, 2, 1'b0, "ex2");
      chk("ex2:i_const", $signed(i_out), 3);
      chk("ex2:cnt_const", step_cnt, 2);

      // Zero-length run
      run(10, 100, 200, 26, 0, 1'b0, "zero");
      chk("zero:i_const", $signed(i_out), 0);

      // Abort after the second step
      @(negedge clk);
      r_coef  = 16'd10;
      l_div   = 16'd100;
      u0      = 16'd200;
      dt      = 16'd26;
      n_steps = 16'd5;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort:i_valid2", i_valid, 1);
      chk("abort:cnt2", step_cnt, 2);
      chk("abort:i2", $signed(i_out), 3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort:busy", busy, 0);
      chk("abort:done", done, 0);
      chk("abort:cnt", step_cnt, 2);
      chk("abort:i_kept", $signed(i_out), 3);
      repeat (24) begin
         @(negedge clk);
         chk("abort:no_done", done, 0);
         chk("abort:idle", busy, 0);
      end
      run(10, 100, 200, 26, 2, 1'b0, "restart");

      // Asynchronous reset in the middle of a step
      @(negedge clk);
      n_steps = 16'd4;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mrst:pre_i", $signed(i_out), 1);
      #2 rst = 1'b1;
      #1;
      chk("mrst:busy", busy, 0);
      chk("mrst:done", done, 0);
      chk("mrst:i_valid", i_valid, 0);
      chk("mrst:i_out", $signed(i_out), 0);
      chk("mrst:cnt", step_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst:stay_idle", busy, 0);

      // Start and coefficient changes while busy must be ignored
      run(10, 100, 200, 26, 3, 1'b1, "noise");

      // Randomized runs
      for (int t = 0; t < 8; t++) begin
         run(shortint'($urandom), shortint'($urandom),
             shortint'($urandom), shortint'($urandom),
             int'($urandom_range(1, 6)), 1'b1, "rand");
      end

      // Long run that overflows the accumulator
      run(0, 1000, 1000, 2000, 1100, 1'b0, "ovf");
`ifdef RL_SEQ_SAT_EN
      chk("ovf:const", $signed(i_out), 8388607);
`else
      chk("ovf:const", $signed(i_out), -8384883);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
